// File: rtl/lte_sym_sched.sv
// rtl/lte_sym_sched.sv - LTE symbol/slot timing scheduler ahead of CP removal
module lte_sym_sched #(
    parameter int DATA_NBIT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [2:0]           cfg_fft_num,
    input  logic                 cfg_cp_type,
    input  logic                 cfg_fft_type,
    input  logic [DATA_NBIT-1:0] din_i,
    input  logic [DATA_NBIT-1:0] din_q,
    input  logic                 din_v,
    input  logic                 din_sync,
    output logic [DATA_NBIT-1:0] sym_i,
    output logic [DATA_NBIT-1:0] sym_q,
    output logic                 sym_v,
    output logic                 sym_h,
    output logic                 sym_s,
    output logic [2:0]           fft_num,
    output logic                 cp_type,
    output logic                 fft_type,
    output logic [2:0]           sym_idx,
    output logic [4:0]           slot_idx,
    output logic                 busy,
    output logic                 cfg_err,
    output logic                 sync_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALIGN,
        S_RUN
    } state_t;

    state_t      state, state_nxt;
    logic [11:0] samp_cnt, samp_nxt;
    logic [2:0]  sym_cnt, sym_nxt;
    logic [4:0]  slot_cnt, slot_nxt;

    logic        align_hit, sync_bad, restart, active, slot_first, cfg_ok;
    logic [11:0] eff_samp, sym_base, sym_len;
    logic [2:0]  eff_sym, lat_fft;
    logic [4:0]  eff_slot;
    logic        lat_cp, lat_type, sym_end, last_sym;

    // eff_* is the position of the incoming sample after any restart;
    // lat_* is the config in force for it, including a fresh slot latch.
    always_comb begin
        state_nxt  = state;
        samp_nxt   = samp_cnt;
        sym_nxt    = sym_cnt;
        slot_nxt   = slot_cnt;

        align_hit  = (state == S_ALIGN) && run && din_v && din_sync;
        sync_bad   = (state == S_RUN) && din_v && din_sync &&
                     !((samp_cnt == 12'd0) && (sym_cnt == 3'd0));
        restart    = align_hit || sync_bad;
        active     = align_hit || ((state == S_RUN) && din_v);

        eff_samp   = restart ? 12'd0 : samp_cnt;
        eff_sym    = restart ? 3'd0  : sym_cnt;
        eff_slot   = restart ? 5'd0  : slot_cnt;

        slot_first = active && (eff_samp == 12'd0) && (eff_sym == 3'd0);
        cfg_ok     = (cfg_fft_num <= 3'd4);
        lat_fft    = (slot_first && cfg_ok) ? cfg_fft_num : fft_num;
        lat_cp     = slot_first ? cfg_cp_type  : cp_type;
        lat_type   = slot_first ? cfg_fft_type : fft_type;

        // N + CP at 2048 scale; every length divides exactly down to 128
        if (lat_cp)
            sym_base = 12'd2560;
        else if (eff_sym == 3'd0)
            sym_base = 12'd2208;
        else
            sym_base = 12'd2192;
        sym_len  = sym_base >> lat_fft;
        sym_end  = (eff_samp == sym_len - 12'd1);
        last_sym = lat_cp ? (eff_sym == 3'd5) : (eff_sym == 3'd6);

        if (active) begin
            if (sym_end) begin
                samp_nxt = 12'd0;
                if (last_sym) begin
                    sym_nxt  = 3'd0;
                    slot_nxt = (eff_slot == 5'd19) ? 5'd0 : eff_slot + 5'd1;
                end else begin
                    sym_nxt  = eff_sym + 3'd1;
                    slot_nxt = eff_slot;
                end
            end else begin
                samp_nxt = eff_samp + 12'd1;
                sym_nxt  = eff_sym;
                slot_nxt = eff_slot;
            end
        end

        case (state)
            S_IDLE:  if (run) state_nxt = S_ALIGN;
            S_ALIGN: begin
                if (!run)
                    state_nxt = S_IDLE;
                else if (align_hit)
                    state_nxt = S_RUN;
            end
            S_RUN:   if (active && sym_end && last_sym && !run) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            samp_cnt <= 12'd0;
            sym_cnt  <= 3'd0;
            slot_cnt <= 5'd0;
        end else begin
            state    <= state_nxt;
            samp_cnt <= samp_nxt;
            sym_cnt  <= sym_nxt;
            slot_cnt <= slot_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sym_i    <= '0;
            sym_q    <= '0;
            sym_v    <= 1'b0;
            sym_h    <= 1'b0;
            sym_s    <= 1'b0;
            fft_num  <= 3'd0;
            cp_type  <= 1'b0;
            fft_type <= 1'b0;
            sym_idx  <= 3'd0;
            slot_idx <= 5'd0;
            busy     <= 1'b0;
            cfg_err  <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            sym_v    <= active;
            sym_h    <= active && (eff_samp == 12'd0);
            sym_s    <= slot_first;
            cfg_err  <= slot_first && !cfg_ok;
            sync_err <= sync_bad;
            busy     <= (state != S_IDLE);
            if (active) begin
                sym_i    <= din_i;
                sym_q    <= din_q;
                sym_idx  <= eff_sym;
                slot_idx <= eff_slot;
            end
            if (slot_first) begin
                fft_num  <= lat_fft;
                cp_type  <= lat_cp;
                fft_type <= lat_type;
            end
        end
    end

endmodule

// File: tb/tb_lte_sym_sched.sv
// tb/tb_lte_sym_sched.sv - directed bench for lte_sym_sched
module tb_lte_sym_sched;

    logic        clk = 1'b0;
    logic        reset, run, cfg_cp_type, cfg_fft_type, din_v, din_sync;
    logic [2:0]  cfg_fft_num;
    logic [14:0] din_i, din_q, sym_i, sym_q;
    logic        sym_v, sym_h, sym_s, cp_type, fft_type, busy, cfg_err, sync_err;
    logic [2:0]  fft_num, sym_idx;
    logic [4:0]  slot_idx;

    lte_sym_sched #(.DATA_NBIT(15)) dut (
        .clk(clk), .reset(reset), .run(run),
        .cfg_fft_num(cfg_fft_num), .cfg_cp_type(cfg_cp_type), .cfg_fft_type(cfg_fft_type),
        .din_i(din_i), .din_q(din_q), .din_v(din_v), .din_sync(din_sync),
        .sym_i(sym_i), .sym_q(sym_q), .sym_v(sym_v), .sym_h(sym_h), .sym_s(sym_s),
        .fft_num(fft_num), .cp_type(cp_type), .fft_type(fft_type),
        .sym_idx(sym_idx), .slot_idx(slot_idx), .busy(busy),
        .cfg_err(cfg_err), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         off;
        logic       s;
        logic [2:0] idx;
        logic [4:0] slot;
        logic [2:0] fft;
        logic       cp;
        logic       ft;
        logic       ce;
        logic       se;
    } hdr_t;

    hdr_t hq[$];
    int vecs = 0, errs = 0;
    int sent = 0, off = 0, gaps = 0;
    int data_bad = 0, gap_bad = 0, n_cfg_err = 0, n_sync_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send1(input logic v, input logic s);
        logic [14:0] d;
        hdr_t h;
        d        = sent[14:0];
        din_v    = v;
        din_sync = s;
        din_i    = d;
        din_q    = ~d;
        @(posedge clk);
        #1;
        if (sym_v) begin
            if (!v) gap_bad++;
            if (sym_i !== d || sym_q !== ~d) data_bad++;
            if (sym_h) begin
                h.off = off; h.s = sym_s; h.idx = sym_idx; h.slot = slot_idx;
                h.fft = fft_num; h.cp = cp_type; h.ft = fft_type;
                h.ce = cfg_err; h.se = sync_err;
                hq.push_back(h);
            end
            off++;
        end
        if (cfg_err) n_cfg_err++;
        if (sync_err) n_sync_err++;
        if (v) sent++;
    endtask

    task automatic send_to(input int target);
        while (sent < target) begin
            if (gaps != 0 && $urandom_range(3) == 0) send1(1'b0, 1'b1);
            send1(1'b1, 1'b0);
        end
    endtask

    int exp_off[45] = '{
        0, 2208, 4400, 6592, 8784, 10976, 13168,
        15360, 17568, 19760, 21952, 24144, 26336, 28528,
        30720, 31824, 32920, 34016, 35112, 36208, 37304,
        38400, 39504, 40600, 41696, 42792,
        43400, 44504, 45600, 46696, 47792, 48888, 49984,
        51080, 51240, 51400, 51560, 51720, 51880,
        52040, 52200, 52360, 52520, 52680, 52840};
    int seg_n[7]    = '{7, 7, 7, 5, 7, 6, 6};
    int seg_slot[7] = '{0, 1, 2, 3, 0, 1, 2};
    int seg_fft[7]  = '{0, 0, 1, 1, 1, 4, 4};
    int seg_cp[7]   = '{0, 0, 0, 0, 0, 1, 1};

    initial begin
        int k;
        reset = 1'b1; run = 1'b0;
        cfg_fft_num = 3'd0; cfg_cp_type = 1'b0; cfg_fft_type = 1'b0;
        din_v = 1'b0; din_sync = 1'b0; din_i = '0; din_q = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sym_v", sym_v, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fft_num", fft_num, 0);
        chk("rst_slot_idx", slot_idx, 0);
        chk("rst_cfg_err", cfg_err, 0);
        reset = 1'b0;

        // idle ignores sync while run is low
        send1(1'b1, 1'b1);
        chk("idle_sym_v", sym_v, 0);
        sent = 0;

        run = 1'b1;
        send1(1'b0, 1'b0);
        send1(1'b0, 1'b0);
        chk("align_busy", busy, 1);

        send1(1'b1, 1'b1);
        send_to(15360);
        send1(1'b1, 1'b1);              // sync on expected slot start
        send_to(20360);
        cfg_fft_num = 3'd1;             // mid-slot change
        send_to(31000);
        cfg_fft_num = 3'd6;             // illegal at next slot latch
        send_to(43400);
        send1(1'b1, 1'b1);              // early sync, sample 5000 of slot 3
        cfg_fft_num = 3'd4; cfg_cp_type = 1'b1; cfg_fft_type = 1'b1;
        gaps = 1;
        send_to(52340);
        gaps = 0;
        run  = 1'b0;
        send_to(52999);
        send1(1'b1, 1'b0);
        chk("stop_last_v", sym_v, 1);
        chk("stop_last_busy", busy, 1);
        send1(1'b1, 1'b0);
        chk("stop_after_v", sym_v, 0);
        chk("stop_after_busy", busy, 0);

        chk("hdr_count", hq.size(), 45);
        chk("sym_v_count", off, 53000);
        chk("data_bad", data_bad, 0);
        chk("gap_bad", gap_bad, 0);
        chk("cfg_err_count", n_cfg_err, 2);
        chk("sync_err_count", n_sync_err, 1);

        k = 0;
        for (int sg = 0; sg < 7; sg++) begin
            for (int j = 0; j < seg_n[sg]; j++) begin
                if (k < hq.size()) begin
                    chk($sformatf("hdr_off[%0d]", k), hq[k].off, exp_off[k]);
                    chk($sformatf("hdr_idx[%0d]", k), hq[k].idx, j);
                    chk($sformatf("hdr_s[%0d]", k), hq[k].s, (j == 0) ? 1 : 0);
                    chk($sformatf("hdr_slot[%0d]", k), hq[k].slot, seg_slot[sg]);
                    chk($sformatf("hdr_fft[%0d]", k), hq[k].fft, seg_fft[sg]);
                    chk($sformatf("hdr_cp[%0d]", k), hq[k].cp, seg_cp[sg]);
                    chk($sformatf("hdr_ft[%0d]", k), hq[k].ft, seg_cp[sg]);
                    chk($sformatf("hdr_ce[%0d]", k), hq[k].ce, (k == 21 || k == 26) ? 1 : 0);
                    chk($sformatf("hdr_se[%0d]", k), hq[k].se, (k == 26) ? 1 : 0);
                end
                k++;
            end
        end

        // reset mid-symbol, then require a fresh run + sync
        run = 1'b1;
        send1(1'b0, 1'b0);
        send1(1'b1, 1'b1);
        chk("rerun_h", sym_h, 1);
        repeat (10) send1(1'b1, 1'b0);
        reset = 1'b1;
        send1(1'b1, 1'b0);
        chk("rst2_sym_v", sym_v, 0);
        chk("rst2_sym_i", sym_i, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_fft_num", fft_num, 0);
        chk("rst2_cp_type", cp_type, 0);
        chk("rst2_sym_idx", sym_idx, 0);
        reset = 1'b0;
        send1(1'b1, 1'b1);
        chk("post_rst_idle_v", sym_v, 0);
        send1(1'b1, 1'b1);
        chk("post_rst_v", sym_v, 1);
        chk("post_rst_h", sym_h, 1);
        chk("post_rst_s", sym_s, 1);
        chk("post_rst_fft", fft_num, 4);
        chk("post_rst_cp", cp_type, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/lte_sym_sched.md
# lte_sym_sched

Symbol/slot timing scheduler in front of the CP-removal preprocessor. Consumes a continuous baseband sample stream plus a slot sync pulse, counts samples against the LTE numerology selected by the configuration, and emits the per-symbol header (`sym_h`), first-symbol-of-slot flag (`sym_s`) and registered configuration that the preprocessor latches on every symbol. It owns all symbol/slot sequencing. The FFT datapath never counts symbols itself.

## Interface
- `DATA_NBIT`, 15, I/Q sample width
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `run`  in  1  level. 1 = start or keep scheduling; 0 = stop at the next slot boundary
- `cfg_fft_num`  in  3  0=2048, 1=1024, 2=512, 3=256, 4=128. Values 5–7 are illegal.
- `cfg_cp_type`  in  1  0 = normal CP, 1 = extended CP
- `cfg_fft_type`  in  1  0 = FFT, 1 = IFFT
- `din_i`, `din_q`  in  DATA_NBIT  sample
- `din_v`  in  1  sample valid
- `din_sync`  in  1  slot-start marker, qualified by `din_v`
- `sym_i`, `sym_q`  out  DATA_NBIT  registered sample
- `sym_v`  out  1  registered valid
- `sym_h`  out  1  first sample of a symbol
- `sym_s`  out  1  with `sym_h`: symbol 0 of a slot
- `fft_num`  out  3  latched config
- `cp_type`  out  1  latched config
- `fft_type`  out  1  latched config
- `sym_idx`  out  3  symbol index in slot: 0–6 normal, 0–5 extended
- `slot_idx`  out  5  slot index in frame, 0–19
- `busy`  out  1  state ≠ IDLE
- `cfg_err`  out  1  one-cycle pulse: illegal `cfg_fft_num` seen at a slot latch
- `sync_err`  out  1  one-cycle pulse: unexpected sync in RUN

## Operation
- States: IDLE, ALIGN, RUN.
- **IDLE → ALIGN** when `run`=1.
- **ALIGN → RUN** on `din_v & din_sync`. That sample is sample 0 of symbol 0, slot 0.
- **RUN → IDLE** at the end of the last sample of a slot when `run`=0.
- **Any state: `run`=0 in ALIGN → IDLE** immediately.
- **Config latch**: `fft_num`, `cp_type` and `fft_type` are latched only on the first sample of each slot. Mid-slot changes to `cfg_*` are ignored.
  - If `cfg_fft_num` > 4, keep the previous `fft_num`, pulse `cfg_err`, and continue.
- **Symbol length** = N + CP.
  - N = 2048 >> `fft_num`.
  - CP = 512 >> `fft_num` for extended.
  - CP = 160 >> `fft_num` for normal symbol 0, and 144 >> `fft_num` for normal symbols 1–6.
  - Compute it from the value being latched on the slot's first sample, not the stale one.
- **Counters**:
  - Sample counter is 12 bits (max 2559).
  - Symbol counter wraps at 7 (normal) or 6 (extended).
  - `slot_idx` wraps 19 → 0.
  - Counters advance only on `din_v`. Gaps in `din_v` freeze all counters.
  - Every slot is 15360 >> `fft_num` valid samples.
- **Headers**:
  - `sym_h` = `din_v` & (sample count == 0) & RUN, including the ALIGN → RUN sample.
  - `sym_s` = `sym_h` & (symbol == 0).
- **Sync in RUN**:
  - A `din_sync` on the expected slot-start sample is accepted silently.
  - A `din_sync` on any other sample restarts at symbol 0, slot 0 on that sample, pulses `sync_err`, re-latches config and issues `sym_h`/`sym_s`.
- **Pass-through**: `sym_v` = `din_v` in RUN only. It is 0 in IDLE and ALIGN.

## Timing
- All outputs are registered. Latency from `din_*` to `sym_*` is 1 cycle.
- `sym_h`, `sym_s`, `sym_idx`, `slot_idx`, `fft_num`, `cp_type` and `fft_type` are aligned with the `sym_v` cycle of the same sample.
  - On a slot's first sample, the output config already shows the new latch.
- `cfg_err` and `sync_err` are aligned with the `sym_v` of the triggering sample.
- Reset values:
  - all `sym_*`, `busy`, `cfg_err`, `sync_err` = 0
  - `sym_idx` = 0, `slot_idx` = 0
  - `fft_num` = 0, `cp_type` = 0, `fft_type` = 0
  - state = IDLE
- Reset mid-slot aborts immediately. The first `sym_v` after reset requires a new `run` and a new sync.
- A stop request (`run`=0) in RUN: the last `sym_v` is the final sample of the current slot. `busy` drops on the cycle after it.

## Test plan
- **Normal CP, 2048**: `run`=1, sync, then 15360 continuous valids.
  - `sym_h` at sample offsets 0, 2208, 4400, 6592, 8784, 10976, 13168.
  - `sym_s` only at offset 0. `sym_idx` runs 0..6.
  - Next `sym_h` at 15360 with `slot_idx`=1.
- **Extended CP, 128** (`cfg_fft_num`=4): `sym_h` every 160 samples, 6 per slot (960 samples).
- **Slot-boundary config change**: change `cfg_fft_num` from 0 to 1 mid-slot.
  - Current slot keeps 2048 lengths.
  - Next slot uses 1104/1096 and `fft_num`=1 appears on its first `sym_v`.
- **Illegal config**: `cfg_fft_num`=6 at a slot start → `cfg_err` pulse, `fft_num` unchanged, timing unchanged.
- **Early sync**: `din_sync` at sample 5000 of slot 3 → `sync_err`, `sym_h`/`sym_s` on that sample, `slot_idx`=0.
- **Valid gaps, stop and reset**:
  - Random `din_v` gaps leave header positions (counted in valid samples) unchanged.
  - `run`=0 at mid-slot → output continues to the slot end, then `busy`=0.
  - `reset` mid-symbol → all outputs 0 the next cycle.
